// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf streaming FIFO: default payload width,
// payload word type and the pointer-width helper.
package leaf_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef logic [DEFAULT_DATA_W-1:0] word_t;

  // A depth of 1 would give a zero-width pointer, so clamp to one bit.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/leaf_stream_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read,
// synchronous clear on rst (clear wins over a concurrent write).
module leaf_stream_fifo_mem
  import leaf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/leaf_stream_fifo.sv
// Leaf streaming FIFO with valid/ready on both sides and occupancy count.
// Define LEAF_STREAM_FIFO_STATS_EN to add push_total and hwm statistics outputs.
module leaf_stream_fifo
  import leaf_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef LEAF_STREAM_FIFO_STATS_EN
  output logic [31:0]       push_total,
  output logic [CNT_W-1:0]  hwm,
`endif
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Ready/valid depend only on the registered count, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  leaf_stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (out_data)
  );

`ifdef LEAF_STREAM_FIFO_STATS_EN
  logic [31:0]      push_total_q, push_total_d;
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // hwm samples the registered count, so a new maximum shows one cycle later.
  always_comb begin
    push_total_d = push_total_q;
    hwm_d        = hwm_q;
    if (push) begin
      push_total_d = push_total_q + 32'd1;
    end
    if (count_q > hwm_q) begin
      hwm_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_total_q <= '0;
      hwm_q        <= '0;
    end else begin
      push_total_q <= push_total_d;
      hwm_q        <= hwm_d;
    end
  end

  assign push_total = push_total_q;
  assign hwm        = hwm_q;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Self-checking bench for leaf_stream_fifo (DATA_W=8, DEPTH=4) against a queue model.
// Stats checks run only when LEAF_STREAM_FIFO_STATS_EN is defined.
module tb_leaf_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
`ifdef LEAF_STREAM_FIFO_STATS_EN
  logic [31:0]       push_total;
  logic [CNT_W-1:0]  hwm;
`endif

  leaf_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef LEAF_STREAM_FIFO_STATS_EN
    .push_total (push_total),
    .hwm        (hwm),
`endif
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: an ordered queue of stored words plus stats counters.
  logic [DATA_W-1:0] model_q [$];
  int                push_total_m = 0;
  int                hwm_m        = 0;

  logic              did_push;
  logic              did_pop;
  logic [DATA_W-1:0] exp_pop_data;
  logic [DATA_W-1:0] pre_out_data;
  logic              pre_out_valid;
  logic              pre_in_ready;

  // Advance one clock: sample the DUT mid-cycle, predict the transfers from the
  // model occupancy, then update the model just after the rising edge.
  task automatic tick();
    int size_before;
    @(negedge clk);
    pre_out_data  = out_data;
    pre_out_valid = out_valid;
    pre_in_ready  = in_ready;
    size_before   = model_q.size();
    did_push      = !rst && in_valid && (size_before != DEPTH);
    did_pop       = !rst && out_ready && (size_before != 0);
    exp_pop_data  = (size_before != 0) ? model_q[0] : '0;
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      push_total_m = 0;
      hwm_m        = 0;
    end else begin
      if (size_before > hwm_m) hwm_m = size_before;
      if (did_pop) void'(model_q.pop_front());
      if (did_push) begin
        model_q.push_back(in_data);
        push_total_m++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
      $display("[TB] FAIL reset_initial: count=%0d out_valid=%b in_ready=%b out_data=%h, want 0/0/1/00",
               count, out_valid, in_ready, out_data);
    else pass_cnt++;

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h01 + i);
      tick();
    end
    total_cnt++;
    if (count !== 3'd3)
      $display("[TB] FAIL reset_preload_count: got %0d want 3", count);
    else pass_cnt++;

    // Reset with a push pending: nothing may be stored on the reset edge.
    in_data = 8'h77; rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
      $display("[TB] FAIL reset_midop: count=%0d out_valid=%b in_ready=%b out_data=%h, want 0/0/1/00",
               count, out_valid, in_ready, out_data);
    else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    logic [DATA_W-1:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = fill[i];
      tick();
    end
    total_cnt++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      $display("[TB] FAIL fill_full: count=%0d in_ready=%b, want 4/0", count, in_ready);
    else pass_cnt++;

    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd4 || out_data !== 8'h11)
      $display("[TB] FAIL fill_reject5: count=%0d head=%h, want 4/11", count, out_data);
    else pass_cnt++;

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (pre_out_valid !== 1'b1 || pre_out_data !== fill[i])
        $display("[TB] FAIL drain_word%0d: valid=%b data=%h, want 1/%h", i, pre_out_valid, pre_out_data, fill[i]);
      else pass_cnt++;
    end
    out_ready = 1'b0;
    total_cnt++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL drain_empty: count=%0d out_valid=%b in_ready=%b, want 0/0/1", count, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick();
    total_cnt++;
    if (pre_out_valid !== 1'b0)
      $display("[TB] FAIL latency_before: out_valid=%b want 0", pre_out_valid);
    else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 3'd1)
      $display("[TB] FAIL latency_after: out_valid=%b out_data=%h count=%0d, want 1/a5/1", out_valid, out_data, count);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (pre_out_data !== 8'hA5 || count !== '0)
      $display("[TB] FAIL latency_pop: data=%h count=%0d, want a5/0", pre_out_data, count);
    else pass_cnt++;
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom_range(0, 255));
      tick();
    end
    in_data = 8'hEE; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (pre_in_ready !== 1'b0 || pre_out_data !== exp_pop_data || did_push !== 1'b0)
      $display("[TB] FAIL full_simul_edge: in_ready=%b data=%h, want 0/%h", pre_in_ready, pre_out_data, exp_pop_data);
    else pass_cnt++;
    total_cnt++;
    if (count !== 3'd3 || in_ready !== 1'b1 || count !== CNT_W'(model_q.size()))
      $display("[TB] FAIL full_simul_after: count=%0d in_ready=%b, want 3/1", count, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    while (model_q.size() != 0) begin
      tick();
      total_cnt++;
      if (pre_out_data !== exp_pop_data)
        $display("[TB] FAIL full_simul_drain: got %h want %h", pre_out_data, exp_pop_data);
      else pass_cnt++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] sent [$];
    logic [DATA_W-1:0] recv [$];
    int                errs = 0;
    int                cyc  = 0;
    in_valid = 1'b0; in_data = 8'($urandom_range(0, 255));
    while (recv.size() < 20 && cyc < 1000) begin
      in_valid  = (sent.size() < 20) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
      if (did_push) begin
        sent.push_back(in_data);
        in_data = 8'($urandom_range(0, 255));
      end
      if (did_pop) begin
        recv.push_back(pre_out_data);
        if (pre_out_data !== exp_pop_data) errs++;
      end
      if (count !== CNT_W'(model_q.size()) || out_valid !== (model_q.size() != 0) ||
          in_ready !== (model_q.size() != DEPTH)) errs++;
      if (model_q.size() != 0 && out_data !== model_q[0]) errs++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (recv.size() != 20)
      $display("[TB] FAIL stream_timeout: received %0d words want 20", recv.size());
    else pass_cnt++;
    total_cnt++;
    if (errs != 0)
      $display("[TB] FAIL stream_model: %0d cycle mismatches, want 0", errs);
    else pass_cnt++;
    total_cnt++;
    if (recv != sent)
      $display("[TB] FAIL stream_order: got %0d words, sequence differs from %0d sent", recv.size(), sent.size());
    else pass_cnt++;
  endtask

`ifdef LEAF_STREAM_FIFO_STATS_EN
  task automatic test_stats();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (push_total !== '0 || hwm !== '0)
      $display("[TB] FAIL stats_reset: push_total=%0d hwm=%0d, want 0/0", push_total, hwm);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 3; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (push_total !== 32'd6 || hwm !== 3'd4)
      $display("[TB] FAIL stats_values: push_total=%0d hwm=%0d, want 6/4", push_total, hwm);
    else pass_cnt++;
    total_cnt++;
    if (push_total !== 32'(push_total_m) || hwm !== CNT_W'(hwm_m))
      $display("[TB] FAIL stats_model: push_total=%0d hwm=%0d, want %0d/%0d", push_total, hwm, push_total_m, hwm_m);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_full_simul();
    test_stream();
`ifdef LEAF_STREAM_FIFO_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/leaf_stream_fifo.md
Name: leaf_stream_fifo

Overview:
- Leaf-level streaming buffer instantiated beneath the generated hierarchy's innermost stage modules.
- Accepts a valid/ready data stream from the upstream stage and presents it, in order, to the downstream consumer.
- Gives the empty hierarchy real sequential content: storage, pointers, occupancy counting and backpressure.

Parameters:
- DATA_W, 8, payload width in bits (1..64).
- DEPTH, 4, number of entries; power of two, 2..64.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds the oldest stored word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  head-of-queue payload.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: rst sampled high at a clk edge gives:
  - wr_ptr, rd_ptr and count = 0;
  - storage cleared to 0;
  - out_valid = 0, out_data = 0, in_ready = 1.
- Reset asserted mid-operation discards all contents on that edge; no transfer completes on that edge.
- Push: in_valid && in_ready at an edge writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at an edge advances rd_ptr modulo DEPTH.
- Output and ready signals:
  - in_ready = (count != DEPTH); registered-state only, with no combinational path from out_ready.
  - out_valid = (count != 0); out_data = mem[rd_ptr], continuously driven.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. There is no same-cycle bypass when empty.
- Count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop.
- Full (count == DEPTH): in_ready = 0 even if out_ready = 1 in that cycle. The pop proceeds, and in_ready rises the next cycle.
- Empty (count == 0): out_valid = 0. A push in that cycle stores the word; no pop occurs.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Ordering is preserved across wrap.
- Protocol rules:
  - The block never drops or duplicates a word.
  - While out_valid = 1 and out_ready = 0, out_data is held stable.
  - Upstream must hold in_data stable while in_valid && !in_ready.
- States are implicit in count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). Transitions occur only by single steps as above.

Optional Feature:
- Macro: LEAF_STREAM_FIFO_STATS_EN.
- When defined, adds two outputs:
  - push_total, 32 bits: counts accepted pushes, wraps at 2^32.
  - hwm, CNT_W bits: high-water mark of count, updated the cycle after a new maximum.
- Both stats outputs reset to 0 on rst.
- When not defined, the ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package leaf_pkg:
  - localparam default DATA_W;
  - typedef for the payload word;
  - function for the pointer-width calculation.
- One natural sub-module, leaf_stream_fifo_mem: DEPTH x DATA_W register array with synchronous write port, asynchronous read port, and synchronous clear on rst.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset while holding 3 words (DEPTH=4) -> after the rst edge: count=0, out_valid=0, out_data=0, in_ready=1.
- Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; a 5th push of 0x55 is not accepted; then pop all -> outputs 0x11..0x44 in order.
- Empty FIFO, push 0xA5 at edge N -> out_valid=0 before edge N, out_valid=1 with out_data=0xA5 after edge N.
- Full FIFO with in_valid=1 and out_ready=1 for one cycle -> only the pop occurs, count 4->3; in_ready=1 the next cycle.
- Continuous push and pop for 20 words with random stalls on both sides -> output sequence equals input sequence, with the pointers wrapping several times.
- With LEAF_STREAM_FIFO_STATS_EN defined: push 6 words and pop 2 after the 3rd -> push_total=6, hwm=4.
